// File: rtl/reg_lock_scoreboard.sv
// Per-register pending-writer counters that produce the lock vector for the launcher.
// Launch handshakes add a writer, writebacks retire them; clamped with sticky error flags.
module reg_lock_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 4,
    parameter int NUM_WB      = 2,
    localparam int RW = $clog2(NUM_REGS),
    localparam int CW = $clog2(MAX_PENDING + 1),
    localparam int TW = CW + RW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 launch_fire_i,
    input  logic                 launch_we_i,
    input  logic [RW-1:0]        launch_rd_i,
    input  logic [NUM_WB-1:0]    wb_valid_i,
    input  logic [NUM_WB*RW-1:0] wb_rd_i,
    output logic [NUM_REGS-1:0]  locks_o,
    output logic [NUM_REGS-1:0]  full_o,
    output logic                 idle_o,
    output logic                 ovf_err_o,
    output logic                 unf_err_o
);

    localparam logic signed [CW+1:0] MAXS = (CW+2)'(MAX_PENDING);
    localparam logic signed [CW+1:0] ONE  = (CW+2)'(1);

    logic [CW-1:0]          r_cnt [NUM_REGS];
    logic [TW-1:0]          r_total;
    logic                   r_ovf;
    logic                   r_unf;

    logic [CW-1:0]          w_cnt_nxt [NUM_REGS];
    logic signed [CW+1:0]   w_sum [NUM_REGS];
    logic [TW-1:0]          w_total_nxt;
    logic                   w_ovf;
    logic                   w_unf;

    always_comb begin
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_total_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_sum[r]     = $signed({2'b00, r_cnt[r]});
            w_cnt_nxt[r] = r_cnt[r];
            if (r != 0) begin
                if (launch_fire_i && launch_we_i && launch_rd_i == RW'(r))
                    w_sum[r] = w_sum[r] + ONE;
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid_i[p] && wb_rd_i[p*RW +: RW] == RW'(r))
                        w_sum[r] = w_sum[r] - ONE;
                end
            end
            // Clamp so a misbehaving launcher or a stray writeback cannot wrap the count
            if (w_sum[r] > MAXS) begin
                w_cnt_nxt[r] = CW'(MAX_PENDING);
                w_ovf        = 1'b1;
            end else if (w_sum[r] < 0) begin
                w_cnt_nxt[r] = '0;
                w_unf        = 1'b1;
            end else begin
                w_cnt_nxt[r] = w_sum[r][CW-1:0];
            end
            w_total_nxt = w_total_nxt + TW'(w_cnt_nxt[r]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
            r_total <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= w_cnt_nxt[r];
            r_total <= w_total_nxt;
            r_ovf   <= r_ovf | w_ovf;
            r_unf   <= r_unf | w_unf;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            locks_o[r] = (r_cnt[r] != '0);
            full_o[r]  = (r_cnt[r] == CW'(MAX_PENDING));
        end
    end

    assign idle_o    = (r_total == '0);
    assign ovf_err_o = r_ovf;
    assign unf_err_o = r_unf;

endmodule
